pwm_width_capture: RTL and testbench

Servo-pulse receiver: measures the high time of an incoming hobby-servo PWM signal (nominally 1000–2000 µs pulses every 20 ms) and reports it as an integer microsecond width. It is the inverse of the per-finger servo PWM generator. It sits on the feedback/loopback path so a servo command (or an RC-receiver channel) can be turned back into the same `width_us` representation the arm controller drives. It validates pulse width and frame period and flags loss of signal.

---
 rtl/servo_pkg.sv | 24 ++
 rtl/sync_edge_detect.sv | 41 ++++
 rtl/pwm_width_capture.sv | 161 ++++++++++++++++
 tb/tb_pwm_width_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// ============================================================================
// Module      : servo_pkg
// Description : Shared servo timing constants and the width-capture state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package servo_pkg;

    localparam int SERVO_NEUTRAL_US = 1500;
    localparam int SERVO_MIN_US     = 500;
    localparam int SERVO_MAX_US     = 2500;
    localparam int SERVO_FRAME_US   = 20000;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchronizer plus delay flop with rise/fall detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= RESET_LEVEL;
            s2_q <= RESET_LEVEL;
            s3_q <= RESET_LEVEL;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

`default_nettype wire

// File: rtl/pwm_width_capture.sv
// ============================================================================
// Module      : pwm_width_capture
// Description : Measures servo PWM high time in microseconds, with range,
//               frame-timeout and lock reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_width_capture
    import servo_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int MIN_US     = SERVO_MIN_US,
    parameter int MAX_US     = SERVO_MAX_US,
    parameter int TIMEOUT_US = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [15:0] width_us,
    output logic        valid,
    output logic        error,
    output logic        locked
);

    localparam int TICKS_PER_US = CLK_HZ / 1_000_000;
    localparam int PRE_W        = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int PER_W        = $clog2(TIMEOUT_US + 1);

    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICKS_PER_US - 1);
    localparam logic [15:0]      c_min      = 16'(MIN_US);
    localparam logic [15:0]      c_max      = 16'(MAX_US);
    localparam logic [15:0]      c_hi_sat   = 16'(MAX_US + 1);
    localparam logic [15:0]      c_neutral  = 16'(SERVO_NEUTRAL_US);
    localparam logic [PER_W-1:0] c_timeout  = PER_W'(TIMEOUT_US);

    logic w_level;
    logic w_rise;
    logic w_fall;

    // Synchronizer resets high so a pulse already in flight at reset release
    // is seen as "high" and waited out rather than measured from mid-pulse.
    sync_edge_detect #(
        .RESET_LEVEL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .level (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    cap_state_e       state_q,  state_d;
    logic [PRE_W-1:0] pre_q,    pre_d;
    logic [15:0]      hi_q,     hi_d;
    logic [PER_W-1:0] per_q,    per_d;
    logic [15:0]      width_q,  width_d;
    logic             valid_q,  valid_d;
    logic             error_q,  error_d;
    logic             locked_q, locked_d;

    logic             w_tick;
    logic [15:0]      w_hi_inc;
    logic [PER_W-1:0] w_per_inc;
    logic             w_timeout;

    assign w_tick    = (pre_q == c_pre_last);
    assign w_hi_inc  = (w_tick && hi_q != c_hi_sat) ? hi_q + 16'd1 : hi_q;
    assign w_per_inc = (w_tick && per_q != c_timeout) ? per_q + PER_W'(1) : per_q;
    assign w_timeout = (state_q != WAIT_LOW) && (w_per_inc == c_timeout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_LOW;
            pre_q    <= '0;
            hi_q     <= '0;
            per_q    <= '0;
            width_q  <= c_neutral;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            hi_q     <= hi_d;
            per_q    <= per_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = (w_rise || w_tick) ? '0 : pre_q + PRE_W'(1);
        hi_d     = hi_q;
        per_d    = per_q;
        width_d  = width_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        locked_d = locked_q;

        case (state_q)
            WAIT_LOW: begin
                per_d = '0;
                if (!w_level) begin
                    state_d = ARMED;
                end
            end
            ARMED, LOW: begin
                per_d = w_per_inc;
                if (w_rise) begin
                    hi_d    = '0;
                    per_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // The tick landing in the fall cycle still belongs to the
                // pulse, giving floor(high_cycles / TICKS_PER_US).
                hi_d  = w_hi_inc;
                per_d = w_per_inc;
                if (w_fall) begin
                    if (w_hi_inc >= c_min && w_hi_inc <= c_max) begin
                        width_d  = w_hi_inc;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                    end
                    state_d = LOW;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase

        // Timeout overrides any edge decision made in the same cycle.
        if (w_timeout) begin
            state_d  = WAIT_LOW;
            per_d    = '0;
            hi_d     = hi_q;
            width_d  = width_q;
            valid_d  = 1'b0;
            error_d  = 1'b1;
            locked_d = 1'b0;
        end
    end

    assign width_us = width_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign locked   = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_width_capture.sv
// ============================================================================
// Module      : tb_pwm_width_capture
// Description : Scoreboard bench for pwm_width_capture at 2 ticks per us.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_width_capture;

    localparam int T   = 2;
    localparam int TO  = 5000;
    localparam int MIN = 500;
    localparam int MAX = 2500;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [15:0] width_us;
    logic        valid;
    logic        error;
    logic        locked;

    pwm_width_capture #(
        .CLK_HZ     (T * 1_000_000),
        .MIN_US     (MIN),
        .MAX_US     (MAX),
        .TIMEOUT_US (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .width_us (width_us),
        .valid    (valid),
        .error    (error),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [15:0] w;
        int          at;
        int          tol;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    logic [15:0] model_w   = 16'd1500;
    int          last_rise = 0;

    // Every strobe must match the oldest expected event in kind, width, lock and cycle.
    always @(negedge clk) begin
        if (valid || error) begin
            n_cmp++;
            if (valid && error) begin
                n_bad++;
                $display("FAIL both_strobes valid=%0b error=%0b required not both high", valid, error);
            end
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe cyc=%0d valid=%0b error=%0b required none", cyc, valid, error);
            end else begin
                got = sb.pop_front();
                n_cmp++;
                if (error !== got.err) begin
                    n_bad++;
                    $display("FAIL strobe_kind error=%0b required %0b", error, got.err);
                end
                n_cmp++;
                if (width_us !== got.w) begin
                    n_bad++;
                    $display("FAIL width width_us=%0d required %0d", width_us, got.w);
                end
                n_cmp++;
                if (locked !== (got.err ? 1'b0 : 1'b1)) begin
                    n_bad++;
                    $display("FAIL locked locked=%0b required %0b", locked, !got.err);
                end
                n_cmp++;
                if (cyc < got.at - got.tol || cyc > got.at + got.tol) begin
                    n_bad++;
                    $display("FAIL strobe_time cyc=%0d required %0d +/- %0d", cyc, got.at, got.tol);
                end
            end
        end
    end

    task automatic pulse(input int hi_cyc, input int lo_cyc);
        int   w;
        exp_t e;
        @(negedge clk);
        pwm_in    = 1'b1;
        last_rise = cyc;
        repeat (hi_cyc) @(negedge clk);
        pwm_in = 1'b0;
        w      = hi_cyc / T;
        e.err  = (w < MIN) || (w > MAX);
        if (!e.err) model_w = 16'(w);
        e.w   = model_w;
        e.at  = cyc + 3;
        e.tol = 0;
        sb.push_back(e);
        repeat (lo_cyc) @(negedge clk);
    endtask

    task automatic test_reset;
        int bad;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (width_us !== 16'd1500 || valid !== 1'b0 || error !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values w=%0d v=%0b e=%0b l=%0b required 1500 0 0 0",
                     width_us, valid, error, locked);
        end
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (width_us !== 16'd1500 || valid || error || locked) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL idle_low bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_frames;
        repeat (3) pulse(1500 * T, 300 * T);
    endtask

    task automatic test_range;
        pulse(1000 * T, 300 * T);
        pulse(2000 * T, 300 * T);
        pulse(2000 * T + 1, 300 * T);
        pulse(2600 * T, 300 * T);
        n_cmp++;
        if (width_us !== 16'd2000 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL after_too_long w=%0d l=%0b required 2000 0", width_us, locked);
        end
    endtask

    task automatic test_glitch;
        pulse(300 * T, 300 * T);
        pulse(1200 * T, 300 * T);
        n_cmp++;
        if (width_us !== 16'd1200 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL after_glitch w=%0d l=%0b required 1200 1", width_us, locked);
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        pulse(1500 * T, 0);
        e.err = 1'b1;
        e.w   = model_w;
        e.at  = last_rise + 3 + TO * T;
        e.tol = 1;
        sb.push_back(e);
        repeat (6000 * T) @(negedge clk);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_lock locked=%0b required 0", locked);
        end
        pulse(1700 * T, 300 * T);
        pulse(1700 * T, 300 * T);
    endtask

    task automatic test_reset_mid_pulse;
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (700 * T) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (width_us !== 16'd1500 || valid !== 1'b0 || error !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset w=%0d v=%0b e=%0b l=%0b required 1500 0 0 0",
                     width_us, valid, error, locked);
        end
        repeat (4) @(negedge clk);
        reset   = 1'b0;
        model_w = 16'd1500;
        repeat (800 * T) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300 * T) @(negedge clk);
        n_cmp++;
        if (width_us !== 16'd1500 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_pulse w=%0d l=%0b required 1500 0", width_us, locked);
        end
        pulse(1800 * T, 300 * T);
        n_cmp++;
        if (width_us !== 16'd1800) begin
            n_bad++;
            $display("FAIL after_reset w=%0d required 1800", width_us);
        end
    endtask

    initial begin
        pwm_in = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_frames();
        test_range();
        test_glitch();
        test_timeout();
        test_reset_mid_pulse();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events left=%0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
